// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage memory access unit: access types,
// controller states and the alignment rule used by the optional check.
package mem_access_unit_pkg;

    localparam logic [2:0] MEM_TYPE_B  = 3'b000;
    localparam logic [2:0] MEM_TYPE_BU = 3'b001;
    localparam logic [2:0] MEM_TYPE_H  = 3'b010;
    localparam logic [2:0] MEM_TYPE_HU = 3'b011;
    localparam logic [2:0] MEM_TYPE_W  = 3'b100;

    typedef enum logic [1:0] {
        MAU_IDLE = 2'd0,
        MAU_BUSY = 2'd1,
        MAU_DONE = 2'd2
    } mau_state_t;

    // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
    function automatic logic mem_misaligned(input logic [2:0] mem_type, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (mem_type)
            MEM_TYPE_B, MEM_TYPE_BU: bad = 1'b0;
            MEM_TYPE_H, MEM_TYPE_HU: bad = offset[0];
            default:                 bad = |offset;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane steering: byte enables, replicated store data and
// sign/zero-extended load data for a little-endian 32-bit data port.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  mem_type,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] byte_shifted;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    assign byte_shifted = load_word >> {offset, 3'b000};
    assign load_byte    = byte_shifted[7:0];
    // Only addr[1] selects a halfword; a set addr[0] is truncated away.
    assign load_half    = offset[1] ? load_word[31:16] : load_word[15:0];

    always_comb begin
        byte_en   = 4'b1111;
        wdata     = store_data;
        load_data = load_word;
        case (mem_type)
            MEM_TYPE_B, MEM_TYPE_BU: begin
                byte_en   = 4'b0001 << offset;
                wdata     = {4{store_data[7:0]}};
                load_data = (mem_type == MEM_TYPE_B) ? {{24{load_byte[7]}}, load_byte}
                                                     : {24'd0, load_byte};
            end
            MEM_TYPE_H, MEM_TYPE_HU: begin
                byte_en   = 4'b0011 << {offset[1], 1'b0};
                wdata     = {2{store_data[15:0]}};
                load_data = (mem_type == MEM_TYPE_H) ? {{16{load_half[15]}}, load_half}
                                                     : {16'd0, load_half};
            end
            default: begin
                byte_en   = 4'b1111;
                wdata     = store_data;
                load_data = load_word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage memory access unit: handshaked RAM access with stall and timeout.
// Optional MEM_ALIGN_CHECK_EN adds addr_err and skips misaligned accesses.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_ren,
    input  logic                  cpu_wen,
    input  logic [2:0]            cpu_type,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [31:0]           cpu_dout,
    output logic [31:0]           cpu_din,
    output logic                  stall,
    output logic                  bus_err,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic [3:0]            ram_be,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata,
    input  logic                  ram_ack
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic                  addr_err
`endif
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mau_state_t              state;
    logic [CNT_W-1:0]        tmo_cnt;
    logic [2:0]              lat_type;
    logic [1:0]              lat_off;
    logic [ADDR_WIDTH-3:0]   lat_word;
    logic [31:0]             lat_dout;
    logic                    lat_we;

    logic                    req;
    logic                    busy;
    logic [3:0]              lane_be;
    logic [31:0]             lane_wdata;
    logic [31:0]             lane_load;

    assign req  = cpu_ren | cpu_wen;
    assign busy = (state == MAU_BUSY);

    mem_lane_align u_lane_align (
        .mem_type   (lat_type),
        .offset     (lat_off),
        .store_data (lat_dout),
        .load_word  (ram_rdata),
        .byte_en    (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

    // RAM side is a pure decode of registered state, gated so idle outputs read 0.
    assign ram_cs    = busy;
    assign ram_we    = busy & lat_we;
    assign ram_be    = busy ? lane_be : '0;
    assign ram_addr  = busy ? {lat_word, 2'b00} : '0;
    assign ram_wdata = busy ? lane_wdata : '0;
    assign stall     = (state == MAU_IDLE) ? req : busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= MAU_IDLE;
            tmo_cnt  <= '0;
            lat_type <= '0;
            lat_off  <= '0;
            lat_word <= '0;
            lat_dout <= '0;
            lat_we   <= 1'b0;
            cpu_din  <= '0;
            bus_err  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            addr_err <= 1'b0;
`endif
        end else begin
            bus_err <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            addr_err <= 1'b0;
`endif
            case (state)
                MAU_IDLE: begin
                    if (req) begin
                        lat_type <= cpu_type;
                        lat_off  <= cpu_addr[1:0];
                        lat_word <= cpu_addr[ADDR_WIDTH-1:2];
                        lat_dout <= cpu_dout;
                        lat_we   <= cpu_wen & ~cpu_ren;
                        tmo_cnt  <= '0;
`ifdef MEM_ALIGN_CHECK_EN
                        if (mem_misaligned(cpu_type, cpu_addr[1:0])) begin
                            cpu_din  <= '0;
                            addr_err <= 1'b1;
                            state    <= MAU_DONE;
                        end else begin
                            state    <= MAU_BUSY;
                        end
`else
                        state <= MAU_BUSY;
`endif
                    end
                end
                MAU_BUSY: begin
                    if (ram_ack) begin
                        cpu_din <= lane_load;
                        state   <= MAU_DONE;
                    end else if (tmo_cnt == CNT_LAST) begin
                        cpu_din <= '0;
                        bus_err <= 1'b1;
                        state   <= MAU_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                MAU_DONE: state <= MAU_IDLE;
                default:  state <= MAU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected RAM requests and load
// results are queued at drive time and popped when the DUT produces them.
module tb_mem_access_unit;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ren, cpu_wen;
    logic [2:0]  cpu_type;
    logic [31:0] cpu_addr, cpu_dout, cpu_din;
    logic        stall, bus_err, ram_cs, ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_ack;
`ifdef MEM_ALIGN_CHECK_EN
    logic        addr_err;
`endif

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(TO), .ADDR_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_ren   (cpu_ren),
        .cpu_wen   (cpu_wen),
        .cpu_type  (cpu_type),
        .cpu_addr  (cpu_addr),
        .cpu_dout  (cpu_dout),
        .cpu_din   (cpu_din),
        .stall     (stall),
        .bus_err   (bus_err),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_be    (ram_be),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ack   (ram_ack)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .addr_err  (addr_err)
`endif
    );

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic [31:0] din;
        logic        berr;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Called at posedge+1; returns at posedge+1 one idle cycle after completion.
    // ack_idx: BUSY cycle (0 = first) in which ram_ack is pulsed, <0 = never.
    task automatic run_access(input string tag, input logic ren, input logic wen,
                              input logic [2:0] typ, input logic [31:0] addr,
                              input logic [31:0] dout, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input logic [31:0] rdata,
                              input int ack_idx, input logic [31:0] exp_din);
        int   stall_n = 0;
        int   cs_n    = 0;
        int   busy_idx = 0;
        int   exp_stall;
        bit   got_req = 0;
        bit   done    = 0;
        req_t r;
        rsp_t p;

        req_q.push_back('{we: wen & ~ren, be: exp_be, addr: addr & 32'hFFFF_FFFC, wdata: exp_wdata});
        rsp_q.push_back('{din: exp_din, berr: (ack_idx < 0)});
        exp_stall = 1 + ((ack_idx < 0) ? int'(TO) : ack_idx + 1);

        cpu_ren = ren; cpu_wen = wen; cpu_type = typ; cpu_addr = addr; cpu_dout = dout;
        for (int cyc = 0; cyc < int'(TO) + 20 && !done; cyc++) begin
            @(negedge clk);
            if (ram_cs) begin
                cs_n++;
                if (!got_req && req_q.size() > 0) begin
                    got_req = 1;
                    r = req_q.pop_front();
                    check({tag, "/we"},    {31'd0, ram_we}, {31'd0, r.we});
                    check({tag, "/be"},    {28'd0, ram_be}, {28'd0, r.be});
                    check({tag, "/addr"},  ram_addr,  r.addr);
                    check({tag, "/wdata"}, ram_wdata, r.wdata);
                end
                if (busy_idx == ack_idx) begin
                    ram_ack   = 1'b1;
                    ram_rdata = rdata;
                end
                busy_idx++;
            end
            if (stall) stall_n++;
            else done = 1;
            if (!done) begin
                @(posedge clk); #1;
                ram_ack = 1'b0;
            end
        end

        if (!done) check({tag, "/completion_timeout"}, 32'd0, 32'd1);
        if (!got_req) check({tag, "/ram_request_seen"}, 32'd0, 32'd1);
        if (rsp_q.size() > 0) begin
            p = rsp_q.pop_front();
            check({tag, "/cpu_din"}, cpu_din, p.din);
            check({tag, "/bus_err"}, {31'd0, bus_err}, {31'd0, p.berr});
        end
        check({tag, "/stall_cycles"}, stall_n, exp_stall);
        check({tag, "/cs_cycles"},    cs_n,    exp_stall - 1);

        @(posedge clk); #1;
        ram_ack = 1'b0; cpu_ren = 1'b0; cpu_wen = 1'b0;
        @(negedge clk);
        check({tag, "/idle_stall"},  {31'd0, stall},   32'd0);
        check({tag, "/idle_berr"},   {31'd0, bus_err}, 32'd0);
        check({tag, "/din_held"},    cpu_din, exp_din);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got hang, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_type = 3'b000;
        cpu_addr = '0; cpu_dout = '0; ram_rdata = '0; ram_ack = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rst/cpu_din",  cpu_din, 32'd0);
        check("rst/stall",    {31'd0, stall},   32'd0);
        check("rst/bus_err",  {31'd0, bus_err}, 32'd0);
        check("rst/ram_cs",   {31'd0, ram_cs},  32'd0);
        check("rst/ram_we",   {31'd0, ram_we},  32'd0);
        check("rst/ram_be",   {28'd0, ram_be},  32'd0);
        check("rst/ram_addr", ram_addr,  32'd0);
        check("rst/ram_wdata", ram_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        //         tag      ren  wen  type    addr          dout          be       wdata         rdata         ack  din
        run_access("sw",    0,   1,   3'b100, 32'h0000_0104, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 32'h0,        2,   32'h0);
        run_access("sb",    0,   1,   3'b000, 32'h0000_0203, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, 32'h0,        0,   32'h0);
        run_access("lb",    1,   0,   3'b000, 32'h0000_0302, 32'h0,         4'b0100, 32'h0,         32'h1280_3456, 1,   32'hFFFF_FF80);
        run_access("lbu",   1,   0,   3'b001, 32'h0000_0302, 32'h0,         4'b0100, 32'h0,         32'h1280_3456, 1,   32'h0000_0080);
        run_access("lhu",   1,   0,   3'b011, 32'h0000_0302, 32'h0,         4'b1100, 32'h0,         32'h1280_3456, 0,   32'h0000_1280);
        run_access("lh",    1,   0,   3'b010, 32'h0000_0100, 32'h0,         4'b0011, 32'h0,         32'h0000_8001, 0,   32'hFFFF_8001);
        run_access("sh",    0,   1,   3'b010, 32'h0000_0106, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF, 32'h0,        3,   32'h0);
        run_access("rw_ld", 1,   1,   3'b100, 32'h0000_0010, 32'h0,         4'b1111, 32'h0,         32'hCAFE_F00D, 0,   32'hCAFE_F00D);
        run_access("tmo",   1,   0,   3'b100, 32'h0000_0040, 32'h0,         4'b1111, 32'h0,         32'h0,        -1,   32'h0);
        run_access("lw",    1,   0,   3'b100, 32'h0000_0020, 32'h0,         4'b1111, 32'h0,         32'h89AB_CDEF, 0,   32'h89AB_CDEF);

        // Stray ack while idle must not disturb the held result.
        @(negedge clk);
        ram_ack = 1'b1; ram_rdata = 32'h5555_5555;
        @(posedge clk); #1;
        ram_ack = 1'b0;
        @(negedge clk);
        check("idle_ack/cpu_din", cpu_din, 32'h89AB_CDEF);
        check("idle_ack/ram_cs",  {31'd0, ram_cs}, 32'd0);
        @(posedge clk); #1;

`ifndef MEM_ALIGN_CHECK_EN
        run_access("lh_mis", 1,  0,   3'b010, 32'h0000_0301, 32'h0,         4'b0011, 32'h0,         32'hABCD_7FFE, 0,   32'h0000_7FFE);
        run_access("lw_mis", 1,  0,   3'b100, 32'h0000_0407, 32'h0,         4'b1111, 32'h0,         32'h0102_0304, 1,   32'h0102_0304);
`endif

        // Reset during the second BUSY cycle abandons the access.
        cpu_ren = 1'b1; cpu_wen = 1'b0; cpu_type = 3'b100; cpu_addr = 32'h0000_0500;
        @(negedge clk);
        check("rstmid/req_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rstmid/busy1_cs", {31'd0, ram_cs}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rstmid/busy2_cs", {31'd0, ram_cs}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cpu_ren = 1'b0;
        @(negedge clk);
        check("rstmid/ram_cs",  {31'd0, ram_cs}, 32'd0);
        check("rstmid/stall",   {31'd0, stall},  32'd0);
        check("rstmid/cpu_din", cpu_din, 32'd0);
        ram_ack = 1'b1; ram_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        ram_ack = 1'b0;
        @(negedge clk);
        check("rstmid/late_ack_din", cpu_din, 32'd0);
        check("rstmid/late_ack_cs",  {31'd0, ram_cs}, 32'd0);
        @(posedge clk); #1;

`ifdef MEM_ALIGN_CHECK_EN
        begin
            int cs_seen = 0;
            cpu_ren = 1'b1; cpu_wen = 1'b0; cpu_type = 3'b100; cpu_addr = 32'h0000_0402;
            @(negedge clk);
            check("align/stall_req", {31'd0, stall}, 32'd1);
            if (ram_cs) cs_seen++;
            @(posedge clk); #1;
            @(negedge clk);
            if (ram_cs) cs_seen++;
            check("align/stall_done", {31'd0, stall},    32'd0);
            check("align/addr_err",   {31'd0, addr_err}, 32'd1);
            check("align/cpu_din",    cpu_din, 32'd0);
            @(posedge clk); #1;
            cpu_ren = 1'b0;
            @(negedge clk);
            if (ram_cs) cs_seen++;
            check("align/addr_err_pulse", {31'd0, addr_err}, 32'd0);
            check("align/cs_never", cs_seen, 0);
            @(posedge clk); #1;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage memory access unit between the pipeline datapath's memory port and a handshaked data RAM/bus.
- Converts the pipeline's word-level request into lane-aligned byte/half/word accesses with byte enables.
- Sign- or zero-extends load data.
- Holds a stall to the hazard/stage-enable logic until the RAM acknowledges or a timeout fires.

Parameters:
- TIMEOUT_CYCLES, 64: cycles to wait for ram_ack before aborting with bus_err.
- ADDR_WIDTH, 32: byte address width.

Ports:
- clk  in  1  main clock.
- rst  in  1  synchronous active-high reset.
- cpu_ren  in  1  load request from the MEM stage.
- cpu_wen  in  1  store request from the MEM stage. Ignored if cpu_ren is also high; that case is a load.
- cpu_type  in  3  access type: 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW; SB/SH/SW use 000/010/100.
- cpu_addr  in  ADDR_WIDTH  byte address (ALU result).
- cpu_dout  in  32  store data, right-justified.
- cpu_din  out  32  load result, extended per cpu_type.
- stall  out  1  freeze IF..MEM, bubble WB.
- bus_err  out  1  one-cycle pulse on timeout.
- ram_cs  out  1  RAM request strobe.
- ram_we  out  1  RAM write enable.
- ram_be  out  4  byte enables; bit i = byte lane [8i+7:8i].
- ram_addr  out  ADDR_WIDTH  word-aligned address, low 2 bits 0.
- ram_wdata  out  32  lane-replicated store data.
- ram_rdata  in  32  RAM read data, valid with ram_ack.
- ram_ack  in  1  RAM completion, one-cycle pulse.

Behaviour:
- Reset outputs: all outputs 0. FSM=IDLE, timeout counter=0, latched request cleared.
- Byte order is little-endian: offset 0 maps to lane 0.
- FSM states are IDLE, BUSY, DONE.
- IDLE:
  - stall = cpu_ren|cpu_wen, combinational.
  - On a request, latch type, addr[1:0], word address, store data and direction, then go to BUSY.
- BUSY:
  - ram_cs=1, ram_we=latched direction, stall=1; timeout counter increments.
  - On ram_ack: capture the extended load data into cpu_din and go to DONE.
  - On counter reaching TIMEOUT_CYCLES-1 with no ack: pulse bus_err, set cpu_din=0, go to DONE.
- DONE:
  - stall=0 and ram_cs=0; cpu_din stays valid. The pipeline advances this cycle.
  - Next state is IDLE unconditionally; the request seen in DONE is the completed one.
- Minimum latency: request at cycle N, ram_ack at N+1 → stall high at N and N+1, low at N+2 (DONE).
- Byte enables:
  - B: 4'b0001<<addr[1:0].
  - H: 4'b0011<<{addr[1],1'b0}.
  - W: 4'b1111.
- Store data replication:
  - Byte stores replicate cpu_dout[7:0] ×4.
  - Halfword stores replicate cpu_dout[15:0] ×2.
- Load extraction:
  - Select the byte or halfword by offset.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Misalignment without the optional feature: offset bits below the access size are ignored. A halfword access uses addr[1] only; a word access ignores addr[1:0].
- cpu_din holds its value until the next completion.
- ram_ack while in IDLE or DONE is ignored.
- rst mid-BUSY: drop ram_cs the next cycle, return to IDLE; the outstanding access is abandoned.
- A timeout count that wraps past the counter width is impossible: the counter is sized clog2(TIMEOUT_CYCLES)+1 and cleared on entry to BUSY.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Extra output addr_err (1 bit).
  - A halfword with addr[0]=1, or a word with addr[1:0]≠0, skips BUSY. IDLE→DONE directly, no ram_cs, cpu_din=0.
  - addr_err pulses for one cycle in DONE, for the CP0 exception path.
- Undefined: no addr_err port; misaligned accesses are truncated as described in Behaviour.

Decomposition:
- Shared package/header mem_access_define.vh:
  - cpu_type encodings (MEM_TYPE_B, MEM_TYPE_BU, MEM_TYPE_H, MEM_TYPE_HU, MEM_TYPE_W).
  - FSM state encodings (MAU_IDLE, MAU_BUSY, MAU_DONE).
- Sub-module mem_lane_align: purely combinational; computes ram_be, replicated ram_wdata and extended load data from type, offset and data. It is instantiated once.

Test Plan:
1. SW addr 0x0000_0104, dout 0xDEADBEEF, ack after 3 cycles → ram_be=1111, ram_addr=0x104, ram_wdata=0xDEADBEEF, stall high 4 cycles, then low for one cycle.
2. SB addr 0x0000_0203, dout 0x0000_00A5 → ram_be=1000, ram_wdata=0xA5A5A5A5, ram_addr=0x200.
3. LB addr 0x0000_0302, rdata 0x1280_3456 → cpu_din=0xFFFF_FF80. LBU, same access → 0x0000_0080. LHU addr 0x0302 → 0x0000_1280.
4. LW with ram_ack never asserted, TIMEOUT_CYCLES=8 → ram_cs high 8 cycles, bus_err pulse, cpu_din=0, stall releases.
5. rst asserted in the second BUSY cycle → next cycle ram_cs=0, stall=0, state IDLE. A late ram_ack has no effect on cpu_din.
6. With MEM_ALIGN_CHECK_EN: LW addr 0x0000_0402 → ram_cs never high, addr_err pulses, stall high exactly one cycle.
